mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM, the MEM stage).
- Sits between the pipeline's fetch/memory stages and the memory port.
- Grants are fixed-priority with DM first, plus a starvation limit that guarantees IF progress.
- Requesters stall on missing grant/response; this block holds only one outstanding memory transaction.

---
 rtl/mem_port_arbiter_pkg.sv | 41 ++++
 rtl/arb_prio_starve.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter and the memory stage.
//   arb_state_t : arbiter FSM states (IDLE / REQ / RSP)
//   owner_t     : which requester owns the outstanding transaction
//   mem_req_t   : one memory request payload {we, be, addr, wdata}
// The payload struct is sized by the package widths so that the memory
// stage and the arbiter agree on a single request format.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Instruction fetch is always a full-word read.
  function automatic mem_req_t if_payload(input logic [MEM_ADDR_W-1:0] addr);
    mem_req_t p;
    p.we    = 1'b0;
    p.be    = '1;
    p.addr  = addr;
    p.wdata = '0;
    return p;
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// Pure arbitration decision between IF and DM.
//   if_req, dm_req : current requests
//   streak         : consecutive DM grants taken while IF was waiting
//   win_valid      : some requester wins this decision
//   winner         : OWN_DM or OWN_IF
//   streak_next    : streak value to register if this decision is used
// DM has fixed priority; once it has won STARVE_LIM times in a row with IF
// waiting, IF wins the next contested decision.
module arb_prio_starve
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  localparam int STREAK_W  = $clog2(STARVE_LIM + 1)
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                win_valid,
  output owner_t              winner,
  output logic [STREAK_W-1:0] streak_next
);

  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIM);

  // ">=" rather than "==" so a corrupted streak can never lock IF out.
  logic if_starved;
  assign if_starved = if_req && (streak >= LIM);

  always_comb begin
    win_valid   = 1'b0;
    winner      = OWN_IF;
    streak_next = streak;
    if (dm_req && !if_starved) begin
      win_valid   = 1'b1;
      winner      = OWN_DM;
      // IF waiting implies streak < LIM here, so the increment cannot overrun.
      streak_next = if_req ? streak + STREAK_W'(1) : '0;
    end else if (if_req) begin
      win_valid   = 1'b1;
      winner      = OWN_IF;
      streak_next = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and the
// data-memory stage (DM). At most one memory transaction is outstanding.
//   clk, rst          : clock, asynchronous active-high reset
//   if_*              : IF read request / grant / response
//   dm_*              : DM read-write request / grant / response
//   mem_*             : memory port (request held until mem_gnt, response
//                       signalled by mem_rvalid for reads and writes)
//   busy              : a transaction is in flight
//   err_spurious      : sticky, mem_rvalid seen with nothing outstanding
// Payload registers use the package request struct, so ADDR_W/DATA_W are
// expected to match the package widths.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err_spurious
);

  localparam int STREAK_W = $clog2(STARVE_LIM + 1);

  arb_state_t          state_reg;
  owner_t              owner_reg;
  mem_req_t            payload_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic                err_reg;

  logic                win_valid;
  owner_t              winner;
  logic [STREAK_W-1:0] streak_next;
  mem_req_t            win_payload;
  logic                arb_en;
  logic                launch;

  arb_prio_starve #(
    .STARVE_LIM (STARVE_LIM)
  ) u_arb (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .streak      (streak_reg),
    .win_valid   (win_valid),
    .winner      (winner),
    .streak_next (streak_next)
  );

  // Arbitrate when idle, or in the response cycle so a pending request can
  // go straight back to REQ without an IDLE bubble.
  assign arb_en = (state_reg == IDLE) || ((state_reg == RSP) && mem_rvalid);
  assign launch = arb_en && win_valid;

  always_comb begin
    win_payload = if_payload(MEM_ADDR_W'(if_addr));
    if (winner == OWN_DM) begin
      win_payload.we    = dm_we;
      win_payload.be    = MEM_BE_W'(dm_be);
      win_payload.addr  = MEM_ADDR_W'(dm_addr);
      win_payload.wdata = MEM_DATA_W'(dm_wdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_IF;
      payload_reg <= '0;
      streak_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (launch) begin
        owner_reg   <= winner;
        payload_reg <= win_payload;
        streak_reg  <= streak_next;
      end
      case (state_reg)
        IDLE: begin
          if (mem_rvalid) err_reg <= 1'b1;
          if (launch) state_reg <= REQ;
        end
        // A response arriving together with the grant cannot belong to this
        // request, so it is flagged rather than forwarded.
        REQ: begin
          if (mem_rvalid) err_reg <= 1'b1;
          if (mem_gnt) state_reg <= RSP;
        end
        RSP: begin
          if (mem_rvalid) state_reg <= launch ? REQ : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_reg == REQ);
  assign mem_we    = payload_reg.we;
  assign mem_be    = (DATA_W/8)'(payload_reg.be);
  assign mem_addr  = ADDR_W'(payload_reg.addr);
  assign mem_wdata = DATA_W'(payload_reg.wdata);

  assign if_gnt    = mem_req && (owner_reg == OWN_IF) && mem_gnt;
  assign dm_gnt    = mem_req && (owner_reg == OWN_DM) && mem_gnt;
  assign if_rvalid = (state_reg == RSP) && (owner_reg == OWN_IF) && mem_rvalid;
  assign dm_rvalid = (state_reg == RSP) && (owner_reg == OWN_DM) && mem_rvalid;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  assign busy         = (state_reg != IDLE);
  assign err_spurious = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents drive queued
// requests, a memory model answers, and a monitor pops expected grants and
// responses in order.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, err_spurious;

  int checks = 0;
  int errors = 0;

  txn_t if_q[$];
  txn_t dm_q[$];
  txn_t exp_txn[$];
  rsp_t exp_rsp[$];
  bit   if_took = 0;
  bit   dm_took = 0;

  // memory model controls
  int          rsp_lat = 1;
  int          stall_left = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  logic        spur_rvalid = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err_spurious(err_spurious)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory model ----------------
  assign mem_gnt    = mem_req && (stall_left == 0);
  assign mem_rvalid = (rsp_cnt == 1) || spur_rvalid;
  assign mem_rdata  = rsp_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_cnt <= 0;
    end else begin
      if (mem_req && mem_gnt) begin
        rsp_cnt  <= rsp_lat;
        rsp_data <= mem_data(mem_addr);
      end else if (rsp_cnt != 0) begin
        rsp_cnt <= rsp_cnt - 1;
      end
      if (mem_req && !mem_gnt && stall_left != 0) stall_left <= stall_left - 1;
    end
  end

  // ---------------- requester agents ----------------
  always @(posedge clk) begin
    #1;
    if (if_took && if_q.size() > 0) if_q.delete(0);
    if (dm_took && dm_q.size() > 0) dm_q.delete(0);
    if_req  = (if_q.size() > 0);
    if_addr = (if_q.size() > 0) ? if_q[0].addr : 32'h0;
    dm_req  = (dm_q.size() > 0);
    if (dm_q.size() > 0) begin
      dm_we    = dm_q[0].we;
      dm_be    = dm_q[0].be;
      dm_addr  = dm_q[0].addr;
      dm_wdata = dm_q[0].wdata;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if_took = 0;
      dm_took = 0;
    end else begin
      if_took = if_gnt;
      dm_took = dm_gnt;
      if (mem_req && mem_gnt) begin
        txn_t t;
        checks++;
        if (exp_txn.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: addr=%h if_gnt=%b dm_gnt=%b, required no grant",
                   mem_addr, if_gnt, dm_gnt);
        end else begin
          t = exp_txn.pop_front();
          if (if_gnt !== !t.is_dm || dm_gnt !== t.is_dm || mem_we !== t.we ||
              mem_be !== t.be || mem_addr !== t.addr || mem_wdata !== t.wdata) begin
            errors++;
            $display("FAIL grant_payload: got if_gnt=%b dm_gnt=%b we=%b be=%h addr=%h wdata=%h, required dm=%0d we=%b be=%h addr=%h wdata=%h",
                     if_gnt, dm_gnt, mem_we, mem_be, mem_addr, mem_wdata,
                     t.is_dm, t.we, t.be, t.addr, t.wdata);
          end
          exp_rsp.push_back('{is_dm: t.is_dm, data: mem_data(t.addr)});
        end
      end
      if (if_rvalid || dm_rvalid) begin
        rsp_t r;
        logic [31:0] got;
        checks++;
        got = dm_rvalid ? dm_rdata : if_rdata;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: if_rvalid=%b dm_rvalid=%b, required none",
                   if_rvalid, dm_rvalid);
        end else begin
          r = exp_rsp.pop_front();
          $display("txn %s rdata=%h", r.is_dm ? "DM" : "IF", got);
          if (if_rvalid !== !r.is_dm || dm_rvalid !== r.is_dm || got !== r.data) begin
            errors++;
            $display("FAIL rsp_data: got if_rvalid=%b dm_rvalid=%b data=%h, required dm=%0d data=%h",
                     if_rvalid, dm_rvalid, got, r.is_dm, r.data);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic push_if(input logic [31:0] a);
    txn_t t = '{is_dm: 0, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
    if_q.push_back(t);
  endtask

  task automatic push_dm(input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
    txn_t t = '{is_dm: 1, we: we, be: be, addr: a, wdata: d};
    dm_q.push_back(t);
  endtask

  task automatic expect_txn(input bit is_dm, input logic we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d);
    txn_t t = '{is_dm: is_dm, we: we, be: be, addr: a, wdata: d};
    exp_txn.push_back(t);
  endtask

  task automatic wait_drained(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !busy && exp_txn.size() == 0 && exp_rsp.size() == 0 &&
             if_q.size() == 0 && dm_q.size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: busy=%b pending_txn=%0d pending_rsp=%0d, required all drained",
               name, busy, exp_txn.size(), exp_rsp.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, err_spurious} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, err_spurious});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, err_spurious} !== 7'b0) begin
      errors++;
      $display("FAIL idle_outputs: got %b, required 0000000",
               {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, err_spurious});
    end
  endtask

  task automatic test_single_if;
    @(negedge clk);
    push_if(32'h100);
    expect_txn(0, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if (if_req !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL if_latency_req: if_req=%b mem_req=%b, required 1 0", if_req, mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || if_gnt !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL if_mem_req: mem_req=%b if_gnt=%b busy=%b, required 1 1 1",
               mem_req, if_gnt, busy);
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL if_response: if_rvalid=%b if_rdata=%h mem_req=%b, required 1 deadbeef 0",
               if_rvalid, if_rdata, mem_req);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL if_busy_fall: busy=%b, required 0", busy);
    end
    wait_drained("single_if");
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    push_dm(1'b1, 4'h3, 32'h2000, 32'h12345678);
    push_if(32'h104);
    expect_txn(1, 1'b1, 4'h3, 32'h2000, 32'h12345678);
    expect_txn(0, 1'b0, 4'hF, 32'h104, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_we !== 1'b1 || mem_be !== 4'h3) begin
      errors++;
      $display("FAIL sim_dm_first: dm_gnt=%b if_gnt=%b we=%b be=%h, required 1 0 1 3",
               dm_gnt, if_gnt, mem_we, mem_be);
    end
    @(negedge clk);
    checks++;
    if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL sim_dm_ack: dm_rvalid=%b if_rvalid=%b, required 1 0", dm_rvalid, if_rvalid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL sim_no_idle: busy=%b mem_req=%b if_gnt=%b, required 1 1 1",
               busy, mem_req, if_gnt);
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL sim_if_rsp: if_rvalid=%b, required 1", if_rvalid);
    end
    wait_drained("simultaneous");
  endtask

  task automatic test_starvation;
    @(negedge clk);
    for (int k = 0; k < 6; k++) push_dm(1'b0, 4'hF, 32'h1000 + 32'(4 * k), 32'h0);
    push_if(32'h200);
    push_if(32'h204);
    // DM x4, IF, DM x2, IF
    for (int k = 0; k < 4; k++) expect_txn(1, 1'b0, 4'hF, 32'h1000 + 32'(4 * k), 32'h0);
    expect_txn(0, 1'b0, 4'hF, 32'h200, 32'h0);
    for (int k = 4; k < 6; k++) expect_txn(1, 1'b0, 4'hF, 32'h1000 + 32'(4 * k), 32'h0);
    expect_txn(0, 1'b0, 4'hF, 32'h204, 32'h0);
    wait_drained("starvation");
  endtask

  task automatic test_back_pressure;
    @(negedge clk);
    stall_left = 5;
    push_dm(1'b1, 4'hC, 32'h40, 32'hCAFEF00D);
    expect_txn(1, 1'b1, 4'hC, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || dm_gnt !== 1'b0 || mem_we !== 1'b1 || mem_be !== 4'hC ||
          mem_addr !== 32'h40 || mem_wdata !== 32'hCAFEF00D) begin
        errors++;
        $display("FAIL bp_hold_%0d: mem_req=%b dm_gnt=%b we=%b be=%h addr=%h wdata=%h, required 1 0 1 c 00000040 cafef00d",
                 c, mem_req, dm_gnt, mem_we, mem_be, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: dm_gnt=%b, required 1", dm_gnt);
    end
    wait_drained("back_pressure");
  endtask

  task automatic test_reset_spurious;
    @(negedge clk);
    rsp_lat = 3;
    push_if(32'h500);
    expect_txn(0, 1'b0, 4'hF, 32'h500, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_wait: busy=%b mem_req=%b if_rvalid=%b, required 1 0 0",
               busy, mem_req, if_rvalid);
    end
    #1;
    rst = 1'b1;
    exp_rsp.delete();
    if_q.delete();
    #1;
    checks++;
    if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_rsp: got %b, required 000000",
               {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_lat = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: busy=%b err=%b, required 0 0", busy, err_spurious);
    end
    spur_rvalid = 1'b1;
    #1;
    checks++;
    if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL spur_routed: if_rvalid=%b dm_rvalid=%b, required 0 0", if_rvalid, dm_rvalid);
    end
    @(negedge clk);
    spur_rvalid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL spur_set: err=%b, required 1", err_spurious);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL spur_sticky: err=%b, required 1", err_spurious);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear: err=%b, required 0", err_spurious);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_if;
    test_simultaneous;
    test_starvation;
    test_back_pressure;
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL no_spur_traffic: err=%b, required 0", err_spurious);
    end
    test_reset_spurious;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
